// File: rtl/lfu_pkg.sv
// lfu_pkg: shared types and constants for the LFU replacement controller.
//   state_e   : controller FSM states
//   CNT_W_DEF : default usage-counter width
//   CNT_MAX   : saturation value of a default-width counter
//   key_t     : scan key {valid, cnt}; invalid ways sort below every valid way
package lfu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      GRANT,
      AGE
   } state_e;

   localparam int unsigned CNT_W_DEF = 8;
   localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic                 vld;
      logic [CNT_W_DEF-1:0] cnt;
   } key_t;

endpackage

// File: rtl/lfu_repl_ctrl_if.sv
// lfu_repl_ctrl_if: access/invalidate and victim handshake bundle.
//   master : tag-lookup stage + line-fill engine side (drives requests, vict_ready)
//   slave  : replacement controller side (drives acc_ready, vict_valid, vict_way)
interface lfu_repl_ctrl_if #(
   parameter int unsigned SIZE  = 4,
   parameter int unsigned WAY_W = $clog2(SIZE)
);

   logic             acc_valid;
   logic             acc_ready;
   logic             acc_hit;
   logic [WAY_W-1:0] acc_way;
   logic             inv_valid;
   logic [WAY_W-1:0] inv_way;
   logic             vict_valid;
   logic [WAY_W-1:0] vict_way;
   logic             vict_ready;

   modport master (
      output acc_valid, acc_hit, acc_way, inv_valid, inv_way, vict_ready,
      input  acc_ready, vict_valid, vict_way
   );

   modport slave (
      input  acc_valid, acc_hit, acc_way, inv_valid, inv_way, vict_ready,
      output acc_ready, vict_valid, vict_way
   );

endinterface

// File: rtl/lfu_cnt_bank.sv
// lfu_cnt_bank: per-way usage counters and valid bits.
//   inc_i/inc_way_i   : saturating increment (ignored on an invalid way)
//   fill_i/fill_way_i : cnt = 0, valid = 1
//   inv_i/inv_way_i   : cnt = 0, valid = 0 (wins over inc on the same way)
//   age_i             : halve every counter
//   rd_way_i          : scan read port -> rd_cnt_o, rd_vld_o
//   dbg_way_i         : debug read port -> dbg_cnt_o, dbg_vld_o
//   inc_sat_o         : the increment at inc_way_i would land on CNT_MAX
module lfu_cnt_bank #(
   parameter int unsigned SIZE  = 4,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned WAY_W = $clog2(SIZE)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic [WAY_W-1:0] inc_way_i,
   input  logic             fill_i,
   input  logic [WAY_W-1:0] fill_way_i,
   input  logic             inv_i,
   input  logic [WAY_W-1:0] inv_way_i,
   input  logic             age_i,
   input  logic [WAY_W-1:0] rd_way_i,
   output logic [CNT_W-1:0] rd_cnt_o,
   output logic             rd_vld_o,
   input  logic [WAY_W-1:0] dbg_way_i,
   output logic [CNT_W-1:0] dbg_cnt_o,
   output logic             dbg_vld_o,
   output logic             inc_sat_o
);

   localparam logic [CNT_W-1:0] MAX_L = '1;

   logic [CNT_W-1:0] cnt_q [SIZE];
   logic [CNT_W-1:0] cnt_d [SIZE];
   logic [SIZE-1:0]  vld_q, vld_d;

   always_comb begin
      cnt_d = cnt_q;
      vld_d = vld_q;
      for (int unsigned w = 0; w < SIZE; w++) begin
         if (age_i) begin
            cnt_d[w] = cnt_q[w] >> 1;
         end else if (inv_i && inv_way_i == WAY_W'(w)) begin
            cnt_d[w] = '0;
            vld_d[w] = 1'b0;
         end else if (fill_i && fill_way_i == WAY_W'(w)) begin
            cnt_d[w] = '0;
            vld_d[w] = 1'b1;
         end else if (inc_i && inc_way_i == WAY_W'(w) && vld_q[w] && cnt_q[w] != MAX_L) begin
            cnt_d[w] = cnt_q[w] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned w = 0; w < SIZE; w++) cnt_q[w] <= '0;
         vld_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         vld_q <= vld_d;
      end
   end

   // Independent of inc_i so the controller can gate it without a comb loop.
   assign inc_sat_o = vld_q[inc_way_i] && (cnt_q[inc_way_i] >= MAX_L - 1'b1)
                      && !(inv_i && inv_way_i == inc_way_i);

   assign rd_cnt_o  = cnt_q[rd_way_i];
   assign rd_vld_o  = vld_q[rd_way_i];
   assign dbg_cnt_o = cnt_q[dbg_way_i];
   assign dbg_vld_o = vld_q[dbg_way_i];

endmodule

// File: rtl/lfu_repl_ctrl.sv
// lfu_repl_ctrl: LFU replacement controller for a small fully-associative cache.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : access/invalidate requests in, victim offer out (slave modport)
//   busy       : controller is not in IDLE
//   dbg_way    : debug read index -> dbg_cnt / dbg_vld (combinational)
// A miss scans one way per cycle in ascending order, keeping the smallest
// {valid, cnt} key (strict compare, so ties keep the lower index), then holds
// the victim on the handshake until the fill engine takes it.
module lfu_repl_ctrl
   import lfu_pkg::*;
#(
   parameter int unsigned SIZE  = 4,
   parameter int unsigned CNT_W = lfu_pkg::CNT_W_DEF,
   parameter int unsigned WAY_W = $clog2(SIZE)
) (
   input  logic             clk,
   input  logic             rst_n,
   lfu_repl_ctrl_if.slave   bus,
   output logic             busy,
   input  logic [WAY_W-1:0] dbg_way,
   output logic [CNT_W-1:0] dbg_cnt,
   output logic             dbg_vld
);

   localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(SIZE - 1);

   state_e           state_q, state_d;
   logic [WAY_W-1:0] idx_q, idx_d;
   logic [CNT_W:0]   best_key_q, best_key_d;
   logic [WAY_W-1:0] best_way_q, best_way_d;

   logic             idle;
   logic             inc, fill, inv, age, inc_sat;
   logic [CNT_W-1:0] rd_cnt;
   logic             rd_vld;

   assign idle = (state_q == IDLE);
   assign inc  = idle && bus.acc_valid && bus.acc_hit;
   assign inv  = idle && bus.inv_valid;
   assign fill = (state_q == GRANT) && bus.vict_ready;
   assign age  = (state_q == AGE);

   lfu_cnt_bank #(
      .SIZE  (SIZE),
      .CNT_W (CNT_W),
      .WAY_W (WAY_W)
   ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_i      (inc),
      .inc_way_i  (bus.acc_way),
      .fill_i     (fill),
      .fill_way_i (best_way_q),
      .inv_i      (inv),
      .inv_way_i  (bus.inv_way),
      .age_i      (age),
      .rd_way_i   (idx_q),
      .rd_cnt_o   (rd_cnt),
      .rd_vld_o   (rd_vld),
      .dbg_way_i  (dbg_way),
      .dbg_cnt_o  (dbg_cnt),
      .dbg_vld_o  (dbg_vld),
      .inc_sat_o  (inc_sat)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      best_key_d = best_key_q;
      best_way_d = best_way_q;
      unique case (state_q)
         IDLE: begin
            if (bus.acc_valid) begin
               if (bus.acc_hit) begin
                  if (inc_sat) state_d = AGE;
               end else begin
                  state_d    = SCAN;
                  idx_d      = '0;
                  best_key_d = '1;
                  best_way_d = '0;
               end
            end
         end
         SCAN: begin
            if ({rd_vld, rd_cnt} < best_key_q) begin
               best_key_d = {rd_vld, rd_cnt};
               best_way_d = idx_q;
            end
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_WAY) state_d = GRANT;
         end
         GRANT: begin
            if (bus.vict_ready) state_d = IDLE;
         end
         AGE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         best_key_q <= '1;
         best_way_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         best_key_q <= best_key_d;
         best_way_q <= best_way_d;
      end
   end

   assign bus.acc_ready  = idle;
   assign bus.vict_valid = (state_q == GRANT);
   assign bus.vict_way   = best_way_q;
   assign busy           = !idle;

endmodule

// File: tb/tb_lfu_repl_ctrl.sv
// tb_lfu_repl_ctrl: directed bench for lfu_repl_ctrl. The driver pushes the
// expected victim and acceptance cycle into a scoreboard; a negedge monitor
// pops and checks whenever vict_valid rises, and checks vict_way stays put.
module tb_lfu_repl_ctrl;
   import lfu_pkg::*;

   localparam int unsigned SIZE  = 4;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned WAY_W = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             busy;
   logic [WAY_W-1:0] dbg_way;
   logic [CNT_W-1:0] dbg_cnt;
   logic             dbg_vld;

   lfu_repl_ctrl_if #(.SIZE(SIZE), .WAY_W(WAY_W)) bus ();

   lfu_repl_ctrl #(
      .SIZE  (SIZE),
      .CNT_W (CNT_W),
      .WAY_W (WAY_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .busy    (busy),
      .dbg_way (dbg_way),
      .dbg_cnt (dbg_cnt),
      .dbg_vld (dbg_vld)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [WAY_W-1:0] way;
      int               acc_cyc;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_dbg(input int w, input int cnt, input int vld);
      dbg_way = WAY_W'(w);
      #1;
      check($sformatf("dbg_cnt[%0d]", w), int'(dbg_cnt), cnt);
      check($sformatf("dbg_vld[%0d]", w), int'(dbg_vld), vld);
   endtask

   // Monitor: vict_valid becomes visible in the (SIZE+1)-th cycle, i.e. SIZE
   // rising edges after the acceptance edge.
   logic             vv_prev = 1'b0;
   logic [WAY_W-1:0] held_way = '0;

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
         vv_prev <= 1'b0;
      end else begin
         if (bus.vict_valid && !vv_prev) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_victim: got way %0d, expected no victim", bus.vict_way);
            end else begin
               e = sb.pop_front();
               check("vict_way", int'(bus.vict_way), int'(e.way));
               check("vict_latency", cyc - e.acc_cyc, int'(SIZE));
            end
         end else if (bus.vict_valid) begin
            check("vict_way_stable", int'(bus.vict_way), int'(held_way));
         end
         held_way <= bus.vict_way;
         vv_prev  <= bus.vict_valid;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!bus.acc_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.acc_ready) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: got acc_ready 0, expected 1 within 20 cycles");
      end
   endtask

   task automatic hit(input int w);
      @(negedge clk);
      bus.acc_valid = 1'b1;
      bus.acc_hit   = 1'b1;
      bus.acc_way   = WAY_W'(w);
      @(negedge clk);
      bus.acc_valid = 1'b0;
      bus.acc_hit   = 1'b0;
      wait_idle();
   endtask

   // Miss with vict_ready held low for 'hold' cycles in GRANT; during the hold
   // an acc_valid pulse (hit on way 0) must be ignored.
   task automatic miss(input int exp_way, input int hold);
      exp_t e;
      int   n;
      @(negedge clk);
      bus.acc_valid = 1'b1;
      bus.acc_hit   = 1'b0;
      @(posedge clk);
      #1;
      e.way     = WAY_W'(exp_way);
      e.acc_cyc = cyc;
      sb.push_back(e);
      @(negedge clk);
      bus.acc_valid = 1'b0;
      n = 0;
      while (!bus.vict_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.vict_valid) begin
         tests++;
         fails++;
         $display("FAIL vict_timeout: got vict_valid 0, expected 1 within 20 cycles");
      end else begin
         for (int i = 0; i < hold; i++) begin
            check("grant_vict_valid", int'(bus.vict_valid), 1);
            check("grant_acc_ready", int'(bus.acc_ready), 0);
            check("grant_busy", int'(busy), 1);
            if (i == 1) begin
               bus.acc_valid = 1'b1;
               bus.acc_hit   = 1'b1;
               bus.acc_way   = '0;
            end else begin
               bus.acc_valid = 1'b0;
               bus.acc_hit   = 1'b0;
            end
            @(negedge clk);
         end
         bus.acc_valid  = 1'b0;
         bus.acc_hit    = 1'b0;
         bus.vict_ready = 1'b1;
         @(negedge clk);
         bus.vict_ready = 1'b0;
         check("vict_valid_after_hs", int'(bus.vict_valid), 0);
      end
      wait_idle();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      bus.acc_valid  = 1'b0;
      bus.acc_hit    = 1'b0;
      bus.acc_way    = '0;
      bus.inv_valid  = 1'b0;
      bus.inv_way    = '0;
      bus.vict_ready = 1'b0;
      dbg_way        = '0;

      // Reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_acc_ready", int'(bus.acc_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_vict_valid", int'(bus.vict_valid), 0);
      check("rst_vict_way", int'(bus.vict_way), 0);
      for (int w = 0; w < 4; w++) chk_dbg(w, 0, 0);

      // All ways invalid: lowest invalid index wins each time
      miss(0, 0);
      chk_dbg(0, 0, 1);
      miss(1, 0);
      miss(2, 0);
      miss(3, 0);

      // Counts 3,1,2,1 -> tie between ways 1 and 3 resolves to 1
      repeat (3) hit(0);
      hit(1);
      repeat (2) hit(2);
      hit(3);
      chk_dbg(0, 3, 1);
      chk_dbg(1, 1, 1);
      chk_dbg(2, 2, 1);
      chk_dbg(3, 1, 1);
      miss(1, 3);
      chk_dbg(1, 0, 1);
      chk_dbg(0, 3, 1);

      // Saturation and aging: way2 254 -> 255 -> AGE -> 127; way0 3 -> 1
      repeat (252) hit(2);
      chk_dbg(2, 254, 1);
      @(negedge clk);
      bus.acc_valid = 1'b1;
      bus.acc_hit   = 1'b1;
      bus.acc_way   = 2'd2;
      @(negedge clk);
      bus.acc_valid = 1'b0;
      bus.acc_hit   = 1'b0;
      dbg_way = 2'd2;
      #1;
      check("age_acc_ready", int'(bus.acc_ready), 0);
      check("age_busy", int'(busy), 1);
      check("sat_cnt", int'(dbg_cnt), int'(CNT_MAX));
      @(negedge clk);
      #1;
      check("post_age_acc_ready", int'(bus.acc_ready), 1);
      chk_dbg(2, 127, 1);
      chk_dbg(0, 1, 1);
      chk_dbg(1, 0, 1);
      chk_dbg(3, 0, 1);

      // Same-cycle invalidate and hit on way3: invalidate wins
      hit(3);
      chk_dbg(3, 1, 1);
      @(negedge clk);
      bus.acc_valid = 1'b1;
      bus.acc_hit   = 1'b1;
      bus.acc_way   = 2'd3;
      bus.inv_valid = 1'b1;
      bus.inv_way   = 2'd3;
      @(negedge clk);
      bus.acc_valid = 1'b0;
      bus.acc_hit   = 1'b0;
      bus.inv_valid = 1'b0;
      #1;
      check("inv_acc_ready", int'(bus.acc_ready), 1);
      chk_dbg(3, 0, 0);
      hit(3);
      chk_dbg(3, 0, 0);
      miss(3, 0);
      chk_dbg(3, 0, 1);

      // Reset during the second SCAN cycle abandons the miss
      @(negedge clk);
      bus.acc_valid = 1'b1;
      bus.acc_hit   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.acc_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_scan_vict_valid", int'(bus.vict_valid), 0);
      check("rst_scan_busy", int'(busy), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_scan_acc_ready", int'(bus.acc_ready), 1);
      check("rst_scan_busy_rel", int'(busy), 0);
      for (int w = 0; w < 4; w++) chk_dbg(w, 0, 0);
      repeat (8) @(negedge clk);
      check("rst_scan_no_victim", int'(bus.vict_valid), 0);
      miss(0, 0);

      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lfu_repl_ctrl.md
Name: lfu_repl_ctrl

Overview:
- Replacement controller for a small fully-associative cache that uses a least-frequently-used policy.
- Holds one usage counter and one valid bit per way.
- Applies hit, invalidate and fill events to those counters.
- On a miss, runs a sequential minimum search and offers the victim way over a valid/ready handshake.
- Sits between the tag-lookup stage and the line-fill engine.

Parameters:
SIZE, 4, number of ways (at least 2)
CNT_W, 8, usage counter width; CNT_MAX = 2^CNT_W-1
WAY_W, $clog2(SIZE), way index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
acc_valid  in  1  access event present
acc_ready  out  1  controller can accept an access or invalidate; high only in IDLE
acc_hit  in  1  1 = hit on acc_way, 0 = miss
acc_way  in  WAY_W  hit way; ignored on a miss
inv_valid  in  1  invalidate request, qualified by acc_ready
inv_way  in  WAY_W  way to invalidate
vict_valid  out  1  victim offered
vict_way  out  WAY_W  victim way index
vict_ready  in  1  fill engine takes the victim
busy  out  1  state != IDLE
dbg_way  in  WAY_W  debug read index
dbg_cnt  out  CNT_W  cnt[dbg_way], combinational
dbg_vld  out  1  valid[dbg_way], combinational

Behaviour:
- Reset: asynchronous, active-low reset on rst_n; clock clk. Reset values:
  - state = IDLE; all cnt = 0; all valid = 0.
  - vict_valid = 0, vict_way = 0, busy = 0, acc_ready = 1.
  - Reset asserted mid-SCAN or mid-GRANT abandons the operation; vict_valid drops immediately.
- States: IDLE, SCAN, GRANT, AGE.
- IDLE, accepted hit (acc_valid and acc_hit):
  - If valid[acc_way] = 0, the hit is ignored; this is a protocol error.
  - Otherwise cnt[acc_way] = min(cnt+1, CNT_MAX).
  - If the new value equals CNT_MAX, next state is AGE.
- IDLE, accepted miss (acc_valid and not acc_hit):
  - Next state SCAN; scan index = 0; best key = all ones.
- IDLE, inv_valid: valid[inv_way] = 0 and cnt[inv_way] = 0.
  - inv_valid and acc_valid in the same cycle are both accepted.
  - If the access is a hit on the same way, the invalidate wins: counter is 0, valid is 0, no AGE.
- SCAN, exactly SIZE cycles, one way per cycle in ascending index order:
  - key = {valid[i], cnt[i]}.
  - Replace best if key < best; strict compare, so ties keep the lower index.
  - Effects: invalid ways always win; among them the lowest index wins.
  - After the last way, next state is GRANT.
- Miss latency: vict_valid rises in the (SIZE+1)-th cycle after the acceptance edge.
- GRANT:
  - vict_valid = 1; vict_way is held stable until the handshake.
  - On vict_valid and vict_ready: cnt[victim] = 0, valid[victim] = 1, next state IDLE.
  - vict_valid is low in the cycle after the handshake.
- AGE, one cycle: every cnt[i] = cnt[i] >> 1 (valid bits unchanged), then IDLE.
- acc_ready = (state == IDLE). No access or invalidate is accepted in SCAN, GRANT or AGE.
- Counters never wrap; CNT_MAX is sticky until the AGE cycle.

Decomposition:
- Package lfu_pkg:
  - state enum {IDLE, SCAN, GRANT, AGE};
  - CNT_MAX constant;
  - key type {valid, cnt} of width CNT_W+1.
- Sub-module lfu_cnt_bank:
  - Holds the counter and valid arrays.
  - Single-cycle ops: inc(way) with saturation, clear(way), inv(way), age_all.
  - Read port for the scan index and dbg_way.
- The FSM, scan registers and handshake stay in lfu_repl_ctrl.

Test Plan:
- Reset, then a miss with all ways invalid -> vict_valid in cycle 5 after acceptance (SIZE=4), vict_way=0; after vict_ready, dbg_vld[0]=1 and dbg_cnt[0]=0.
- Fill all four ways, then hits way0 x3, way1 x1, way2 x2, way3 x1, then a miss -> vict_way=1 (tie with way3, lower index); cnt[1]=0 after the grant.
- Hold vict_ready low for 3 cycles in GRANT -> vict_valid=1 and vict_way constant, acc_ready=0, busy=1; an acc_valid pulse has no effect.
- Way2 at cnt 254, way0 at cnt 3, one hit on way2 -> cnt2=255, then AGE for one cycle (acc_ready=0) -> cnt2=127, cnt0=1.
- Same-cycle inv_valid and hit on way3 -> dbg_cnt=0, dbg_vld=0; the next miss returns vict_way=3 even with all other ways valid.
- Assert rst_n=0 in the 2nd SCAN cycle -> vict_valid stays 0, all counters 0, state IDLE, acc_ready=1 after release.
